// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl
// Brief    : Two-stage RV32M multiply wrapper around a combinational multiplier
//            (operand extension in S1, result word select in S2).
// Revision : 1.0 - initial release
// ============================================================================
module mul_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [4:0]        in_rd,
  output logic [XLEN:0]     mul_x,
  output logic [XLEN:0]     mul_y,
  input  logic [2*XLEN+1:0] mul_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [4:0]        out_rd,
  output logic              busy
);

  localparam logic [1:0] c_OP_MUL   = 2'b00;
  localparam logic [1:0] c_OP_MULH  = 2'b01;
  localparam logic [1:0] c_OP_MULHU = 2'b11;

  logic            r_valid1;
  logic [1:0]      r_op1;
  logic [4:0]      r_rd1;
  logic [XLEN:0]   r_x1;
  logic [XLEN:0]   r_y1;
  logic            r_valid2;
  logic [XLEN-1:0] r_data2;
  logic [4:0]      r_rd2;

  logic w_s2_ready;
  logic w_s1_adv;
  logic w_s1_load;
  logic w_sx;
  logic w_sy;
  logic w_z_unused;

  assign w_s2_ready = !r_valid2 | out_ready;
  assign w_s1_adv   = r_valid1 & w_s2_ready;
  assign in_ready   = !flush & (!r_valid1 | w_s2_ready);
  assign w_s1_load  = in_valid & in_ready;

  assign w_sx = (in_op != c_OP_MULHU);
  assign w_sy = (in_op == c_OP_MUL) | (in_op == c_OP_MULH);

  // The two guard bits of the 66-bit product never reach the result.
  assign w_z_unused = ^mul_z[2*XLEN+1:2*XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
    end else if (flush) begin
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
    end else begin
      if (w_s1_load)
        r_valid1 <= 1'b1;
      else if (w_s1_adv)
        r_valid1 <= 1'b0;
      if (w_s2_ready)
        r_valid2 <= w_s1_adv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1 <= '0;
      r_rd1 <= '0;
      r_x1  <= '0;
      r_y1  <= '0;
    end else if (w_s1_load) begin
      r_op1 <= in_op;
      r_rd1 <= in_rd;
      r_x1  <= {w_sx & in_rs1[XLEN-1], in_rs1};
      r_y1  <= {w_sy & in_rs2[XLEN-1], in_rs2};
    end
  end

  // Skip the S2 update on a flush; the contents are dead anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data2 <= '0;
      r_rd2   <= '0;
    end else if (w_s1_adv & !flush) begin
      r_data2 <= (r_op1 == c_OP_MUL) ? mul_z[XLEN-1:0] : mul_z[2*XLEN-1:XLEN];
      r_rd2   <= r_rd1;
    end
  end

  assign mul_x     = r_x1;
  assign mul_y     = r_y1;
  assign out_valid = r_valid2;
  assign out_data  = r_data2;
  assign out_rd    = r_rd2;
  assign busy      = r_valid1 | r_valid2;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_ctrl
// Brief    : Self-checking bench for mul_ctrl with a behavioural multiplier
//            and a 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic [32:0] mul_x;
  logic [32:0] mul_y;
  logic [65:0] mul_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mul_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external multiplier: signed 33 x 33 -> 66.
  assign mul_z = 66'($signed({{33{mul_x[32]}}, mul_x}) * $signed({{33{mul_y[32]}}, mul_y}));

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      2'b00:   p = 64'(sa * sb);
      2'b01:   p = 64'(sa * sb);
      2'b10:   p = 64'(sa * ub);
      default: p = 64'(ua * ub);
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic set_idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_op    = 2'b00;
    in_rs1   = '0;
    in_rs2   = '0;
    in_rd    = '0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_rd    = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    out_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0 ||
        mul_x !== 33'd0 || mul_y !== 33'd0)
    begin
      n_err++;
      $display("FAIL reset_state: out_valid=%b busy=%b data=%h rd=%0d x=%h y=%h, want all zero",
               out_valid, busy, out_data, out_rd, mul_x, mul_y);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); set_op(2'b00, 32'd5, 32'd6, 5'd9);
    @(negedge clk); set_op(2'b11, 32'hFFFF_FFFF, 32'd2, 5'd10);
    @(negedge clk); set_idle(); #1;
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_inflight: busy=%b out_valid=%b, want 1 1", busy, out_valid);
    end
    rst = 1'b1; #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mul_x !== 33'd0 || mul_y !== 33'd0 ||
        out_data !== 32'd0 || out_rd !== 5'd0)
    begin
      n_err++;
      $display("FAIL reset_async: out_valid=%b busy=%b x=%h y=%h data=%h rd=%0d, want zeros",
               out_valid, busy, mul_x, mul_y, out_data, out_rd);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); set_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd17);
    @(negedge clk); set_idle(); #1;
    n_vec++;
    if (out_valid !== 1'b0 || mul_x !== 33'h1_FFFF_FFFF || mul_y !== 33'h0_0000_0002) begin
      n_err++;
      $display("FAIL reset_first_s1: out_valid=%b x=%h y=%h, want 0 1ffffffff 000000002",
               out_valid, mul_x, mul_y);
    end
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_rd !== 5'd17) begin
      n_err++;
      $display("FAIL reset_first_out: valid=%b data=%h rd=%0d, want 1 ffffffff 17",
               out_valid, out_data, out_rd);
    end
    @(negedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drain: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  t_op [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [31:0] t_a  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_e  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_op(t_op[i], t_a[i], t_b[i], 5'(i + 3));
      @(negedge clk); set_idle(); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL arith_latency[%0d]: out_valid=%b one cycle after accept, want 0", i, out_valid);
      end
      @(negedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== t_e[i] || out_rd !== 5'(i + 3)) begin
        n_err++;
        $display("FAIL arith[%0d] op=%0d: valid=%b data=%h rd=%0d, want 1 %h %0d",
                 i, t_op[i], out_valid, out_data, out_rd, t_e[i], i + 3);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_d [8];
    logic [4:0]  e_r [8];
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 8) begin
        set_op(2'($urandom), pick_opnd(), pick_opnd(), 5'(c + 1));
        e_d[c] = ref_mul(in_op, in_rs1, in_rs2);
        e_r[c] = 5'(c + 1);
      end else begin
        set_idle();
      end
      #1;
      if (c < 8) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_in_ready[%0d]: in_ready=%b, want 1", c, in_ready);
        end
      end
      n_vec++;
      if (c >= 2 && c < 10) begin
        if (out_valid !== 1'b1 || out_data !== e_d[c-2] || out_rd !== e_r[c-2]) begin
          n_err++;
          $display("FAIL b2b_out[%0d]: valid=%b data=%h rd=%0d, want 1 %h %0d",
                   c - 2, out_valid, out_data, out_rd, e_d[c-2], e_r[c-2]);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle[%0d]: out_valid=%b, want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  p_op [4];
    logic [31:0] p_a  [4];
    logic [31:0] p_b  [4];
    logic [31:0] e_d  [4];
    int in_idx  = 0;
    int out_idx = 0;
    for (int i = 0; i < 4; i++) begin
      p_op[i] = 2'($urandom);
      p_a[i]  = pick_opnd();
      p_b[i]  = pick_opnd();
      e_d[i]  = ref_mul(p_op[i], p_a[i], p_b[i]);
    end
    for (int c = 0; c < 20 && out_idx < 4; c++) begin
      @(negedge clk);
      if (in_idx < 4) set_op(p_op[in_idx], p_a[in_idx], p_b[in_idx], 5'(20 + in_idx));
      else set_idle();
      out_ready = (c >= 5);
      #1;
      if (c >= 2 && c < 5) begin
        n_vec++;
        if (in_ready !== 1'b0 || in_idx !== 2 || out_valid !== 1'b1 ||
            out_data !== e_d[0] || out_rd !== 5'd20)
        begin
          n_err++;
          $display("FAIL bp_hold[%0d]: in_ready=%b accepted=%0d valid=%b data=%h rd=%0d, want 0 2 1 %h 20",
                   c, in_ready, in_idx, out_valid, out_data, out_rd, e_d[0]);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_data !== e_d[out_idx] || out_rd !== 5'(20 + out_idx)) begin
          n_err++;
          $display("FAIL bp_out[%0d]: data=%h rd=%0d, want %h %0d",
                   out_idx, out_data, out_rd, e_d[out_idx], 20 + out_idx);
        end
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
    end
    @(negedge clk); set_idle(); #1;
    n_vec++;
    if (out_idx !== 4 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_complete: delivered=%0d valid=%b busy=%b, want 4 0 0", out_idx, out_valid, busy);
    end
  endtask

  task automatic test_flush();
    logic [31:0] e_a;
    out_ready = 1'b1;
    @(negedge clk); set_op(2'b00, 32'd11, 32'd13, 5'd25);
    e_a = 32'd143;
    @(negedge clk); set_op(2'b11, 32'hFFFF_FFFF, 32'd3, 5'd26);
    @(negedge clk); set_op(2'b01, 32'd9, 32'd9, 5'd27); flush = 1'b1; #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== e_a || out_rd !== 5'd25) begin
      n_err++;
      $display("FAIL flush_cycle: in_ready=%b valid=%b data=%h rd=%0d, want 0 1 %h 25",
               in_ready, out_valid, out_data, out_rd, e_a);
    end
    @(negedge clk); set_idle(); #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_ghost[%0d]: out_valid=%b rd=%0d, want 0", c, out_valid, out_rd);
      end
    end
  endtask

  task automatic test_random();
    logic [36:0] q[$];
    logic [36:0] e;
    logic        hold = 1'b0;
    logic [31:0] hd = '0;
    logic [4:0]  hr = '0;
    int          acc = 0;
    int          cyc = 0;
    while ((acc < 10000 || q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      set_op(2'($urandom), pick_opnd(), pick_opnd(), 5'($urandom));
      in_valid  = (acc < 10000) && ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_vec++;
      if (busy !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL rnd_busy: busy=%b with %0d in flight", busy, q.size());
      end
      if (hold) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== hd || out_rd !== hr) begin
          n_err++;
          $display("FAIL rnd_stall: valid=%b data=%h rd=%0d, want 1 %h %0d",
                   out_valid, out_data, out_rd, hd, hr);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_spurious: data=%h rd=%0d, want no result", out_data, out_rd);
        end else begin
          e = q.pop_front();
          if (out_data !== e[31:0] || out_rd !== e[36:32]) begin
            n_err++;
            $display("FAIL rnd_result: data=%h rd=%0d, want %h %0d",
                     out_data, out_rd, e[31:0], e[36:32]);
          end
        end
      end
      hold = out_valid && !out_ready;
      hd   = out_data;
      hr   = out_rd;
      if (in_valid && in_ready) begin
        q.push_back({in_rd, ref_mul(in_op, in_rs1, in_rs2)});
        acc++;
      end
      cyc++;
    end
    @(negedge clk); set_idle();
    n_vec++;
    if (acc < 10000 || q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_timeout: accepted=%0d pending=%0d, want 10000 0", acc, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
